// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU/DMA memory bus arbiter: owner encoding,
// idle strobe pattern and counter sizing.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    DMA_OWN = 2'd1,
    COOL    = 2'd2
  } owner_t;

  // {oe, we} with both active-low strobes released
  localparam logic [1:0] STROBE_IDLE = 2'b11;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_bus_mux.sv
// Combinational owner select of the external memory bus pins.
module mem_bus_mux
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_sel,
  input  logic              dma_xfer,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_mem_oe,
  input  logic              cpu_mem_we,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_dout
);

  always_comb begin
    mem_addr         = cpu_addr;
    mem_dout         = cpu_dout;
    {mem_oe, mem_we} = {cpu_mem_oe, cpu_mem_we};
    if (dma_sel) begin
      mem_addr         = dma_addr;
      mem_dout         = dma_wdata;
      {mem_oe, mem_we} = STROBE_IDLE;
      // write strobe only in the clk-high half, like a CPU store
      if (dma_xfer && dma_we) begin
        {mem_oe, mem_we} = {1'b0, ~clk};
      end
    end
    if (!rst) begin
      {mem_oe, mem_we} = STROBE_IDLE;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory bus between the CPU and a DMA requester,
// stalling the CPU during bounded DMA bursts.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int CPU_MIN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_mem_oe,
  input  logic              cpu_mem_we,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_run,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din
);

  localparam int BW = cnt_w(MAX_BURST);
  localparam int CW = cnt_w(CPU_MIN);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [CW-1:0] COOL_LAST  = CW'(CPU_MIN - 1);

  owner_t          state_reg, state_next;
  logic [BW-1:0]   burst_cnt_reg, burst_cnt_next;
  logic [CW-1:0]   cool_cnt_reg, cool_cnt_next;
  logic            cpu_run_reg;
  logic            dma_sel;
  logic            dma_xfer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= CPU_OWN;
      burst_cnt_reg <= '0;
      cool_cnt_reg  <= '0;
      cpu_run_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
      cool_cnt_reg  <= cool_cnt_next;
      // registered from the next owner so the CPU never ticks on a DMA-owned edge
      cpu_run_reg   <= (state_next != DMA_OWN);
    end
  end

  always_comb begin
    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    cool_cnt_next  = cool_cnt_reg;
    case (state_reg)
      CPU_OWN: begin
        if (dma_req) begin
          state_next     = DMA_OWN;
          burst_cnt_next = '0;
        end
      end
      DMA_OWN: begin
        if (dma_req) begin
          if (burst_cnt_reg == BURST_LAST) begin
            state_next    = COOL;
            cool_cnt_next = '0;
          end else begin
            burst_cnt_next = burst_cnt_reg + 1'b1;
          end
        end else begin
          state_next = CPU_OWN;
        end
      end
      COOL: begin
        cool_cnt_next = cool_cnt_reg + 1'b1;
        if (cool_cnt_reg == COOL_LAST) begin
          if (dma_req) begin
            state_next     = DMA_OWN;
            burst_cnt_next = '0;
          end else begin
            state_next = CPU_OWN;
          end
        end
      end
      default: state_next = CPU_OWN;
    endcase
  end

  always_comb begin
    dma_sel  = (state_reg == DMA_OWN);
    dma_xfer = dma_sel && dma_req && rst;
  end

  assign dma_ack   = dma_xfer;
  assign cpu_run   = cpu_run_reg;
  assign cpu_din   = mem_din;
  assign dma_rdata = mem_din;

  mem_bus_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .clk        (clk),
    .rst        (rst),
    .dma_sel    (dma_sel),
    .dma_xfer   (dma_xfer),
    .dma_we     (dma_we),
    .cpu_addr   (cpu_addr),
    .cpu_mem_oe (cpu_mem_oe),
    .cpu_mem_we (cpu_mem_we),
    .cpu_dout   (cpu_dout),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .mem_addr   (mem_addr),
    .mem_oe     (mem_oe),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: bus-ownership model checked in both clock phases
// plus directed literal checks of reset, single transfers and burst limits.
module tb_mem_bus_arbiter;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int CPU_MIN   = 1;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_mem_oe;
  logic              cpu_mem_we;
  logic [DATA_W-1:0] cpu_dout;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_run;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_oe;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem_din;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST),
    .CPU_MIN   (CPU_MIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_mem_oe (cpu_mem_oe),
    .cpu_mem_we (cpu_mem_we),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .cpu_run    (cpu_run),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_oe     (mem_oe),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: DMA holds the bus for at most MAX_BURST transfers,
  // then the CPU is guaranteed CPU_MIN cycles before DMA may return.
  bit m_dma;
  int m_streak;
  int m_guard;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_dma    <= 1'b0;
      m_streak <= 0;
      m_guard  <= 0;
    end else if (m_guard > 0) begin
      m_guard <= m_guard - 1;
      if (m_guard == 1 && dma_req) begin
        m_dma    <= 1'b1;
        m_streak <= 0;
      end
    end else if (m_dma) begin
      if (dma_req) begin
        if (m_streak + 1 == MAX_BURST) begin
          m_dma   <= 1'b0;
          m_guard <= CPU_MIN;
        end else begin
          m_streak <= m_streak + 1;
        end
      end else begin
        m_dma <= 1'b0;
      end
    end else if (dma_req) begin
      m_dma    <= 1'b1;
      m_streak <= 0;
    end
  end

  task automatic compare_outputs();
    logic exp_ack;
    logic [1:0] exp_str;
    exp_ack = rst && m_dma && dma_req;
    if (!rst || (m_dma && !exp_ack)) exp_str = 2'b11;
    else if (exp_ack) exp_str = dma_we ? {1'b0, ~clk} : 2'b11;
    else exp_str = {cpu_mem_oe, cpu_mem_we};
    chk("model_dma_ack", dma_ack, exp_ack);
    chk("model_cpu_run", cpu_run, !m_dma);
    chk("model_strobes", {mem_oe, mem_we}, exp_str);
    chk("model_cpu_din", cpu_din, mem_din);
    if (exp_ack) begin
      chk("model_dma_addr", mem_addr, dma_addr);
      chk("model_dma_dout", mem_dout, dma_wdata);
      chk("model_dma_rdata", dma_rdata, mem_din);
    end else if (!m_dma) begin
      chk("model_cpu_addr", mem_addr, cpu_addr);
      chk("model_cpu_dout", mem_dout, cpu_dout);
    end
  endtask

  // Sample once in the clk-high half and once in the clk-low half
  always begin
    @(posedge clk);
    #3;
    compare_outputs();
    #10;
    compare_outputs();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [14:0] ack_hist;
  logic [14:0] run_hist;
  logic [4:0]  ack5;

  initial begin
    rst        = 1'b0;
    dma_req    = 1'b1;
    dma_we     = 1'b0;
    dma_addr   = 16'h0000;
    dma_wdata  = 8'h00;
    cpu_addr   = 16'hBEEF;
    cpu_dout   = 8'h11;
    cpu_mem_oe = 1'b1;
    cpu_mem_we = 1'b1;
    mem_din    = 8'h3C;

    // Reset held with a pending request
    repeat (2) step();
    #2;
    chk("rst_mem_oe", mem_oe, 1'b1);
    chk("rst_mem_we", mem_we, 1'b1);
    chk("rst_dma_ack", dma_ack, 1'b0);
    chk("rst_cpu_run", cpu_run, 1'b1);
    step();
    rst = 1'b1;
    #2;
    chk("release_cycle_no_ack", dma_ack, 1'b0);
    step();
    #2;
    chk("first_ack_after_release", dma_ack, 1'b1);
    step();
    dma_req = 1'b0;
    step();
    step();

    // Single DMA write
    cpu_mem_oe = 1'b0;
    cpu_mem_we = 1'b1;
    dma_req    = 1'b1;
    dma_we     = 1'b1;
    dma_addr   = 16'h1234;
    dma_wdata  = 8'h5A;
    step();
    #2;
    chk("wr_ack", dma_ack, 1'b1);
    chk("wr_addr", mem_addr, 16'h1234);
    chk("wr_dout", mem_dout, 8'h5A);
    chk("wr_we_clk_high", mem_we, 1'b0);
    chk("wr_oe_clk_high", mem_oe, 1'b0);
    chk("wr_cpu_stalled", cpu_run, 1'b0);
    #10;
    chk("wr_we_clk_low", mem_we, 1'b1);
    chk("wr_oe_clk_low", mem_oe, 1'b0);
    step();
    dma_req = 1'b0;
    step();
    step();
    #2;
    chk("wr_cpu_bus_restored", mem_addr, 16'hBEEF);
    chk("wr_cpu_oe_restored", mem_oe, 1'b0);
    chk("wr_cpu_run_back", cpu_run, 1'b1);

    // Single DMA read
    cpu_mem_oe = 1'b1;
    dma_req    = 1'b1;
    dma_we     = 1'b0;
    dma_addr   = 16'h00FF;
    mem_din    = 8'hC3;
    step();
    #2;
    chk("rd_ack", dma_ack, 1'b1);
    chk("rd_rdata", dma_rdata, 8'hC3);
    chk("rd_addr", mem_addr, 16'h00FF);
    chk("rd_oe", mem_oe, 1'b1);
    chk("rd_we", mem_we, 1'b1);
    step();
    dma_req = 1'b0;
    step();
    step();

    // Continuous request: bursts capped at MAX_BURST, then a forced CPU slot
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 16'h4000;
    dma_wdata = 8'hA5;
    mem_din   = 8'h96;
    for (int i = 0; i < 15; i++) begin
      step();
      #2;
      ack_hist = {ack_hist[13:0], dma_ack};
      run_hist = {run_hist[13:0], cpu_run};
      dma_addr = dma_addr + 16'd1;
    end
    chk("burst_ack_pattern", ack_hist, 15'b111101111011110);
    chk("burst_run_pattern", run_hist, 15'b000010000100001);
    dma_req = 1'b0;
    step();
    step();

    // Request dropped after two acks, then burst count restarts
    dma_req   = 1'b1;
    dma_addr  = 16'h2000;
    dma_wdata = 8'h77;
    step();
    #2;
    chk("drop_ack1", dma_ack, 1'b1);
    step();
    #2;
    chk("drop_ack2", dma_ack, 1'b1);
    step();
    dma_req = 1'b0;
    #2;
    chk("drop_no_ack", dma_ack, 1'b0);
    chk("drop_strobes_idle", {mem_oe, mem_we}, 2'b11);
    step();
    #2;
    chk("drop_cpu_run", cpu_run, 1'b1);
    dma_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      #2;
      ack5 = {ack5[3:0], dma_ack};
    end
    chk("restart_full_burst", ack5, 5'b11110);
    dma_req = 1'b0;
    step();
    step();

    // Reset in the middle of a write burst, during the strobe phase
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 16'h3000;
    dma_wdata = 8'h99;
    step();
    step();
    #5;
    chk("mid_we_before_rst", mem_we, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_we_cut", mem_we, 1'b1);
    chk("mid_rst_oe", mem_oe, 1'b1);
    chk("mid_rst_ack", dma_ack, 1'b0);
    chk("mid_rst_cpu_run", cpu_run, 1'b1);
    step();
    step();
    rst = 1'b1;
    #2;
    chk("post_rst_cpu_run", cpu_run, 1'b1);
    chk("post_rst_no_ack", dma_ack, 1'b0);
    dma_req = 1'b0;
    step();
    step();
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between the CPU core and one DMA requester, e.g. a program loader or video fetch.
- Stalls the CPU by withholding its clock enable while a DMA transfer owns the bus.
- Bounds DMA bursts so the CPU always makes progress.
- Sits between the core's memory pins (address, data, active-low oe/we) and the board memory.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
MAX_BURST, 4, max consecutive DMA transfer cycles before forced CPU slot (>=1)
CPU_MIN, 1, CPU cycles granted after a maxed-out burst (>=1)

Ports:
clk  in  1  system clock; all state changes on posedge
rst  in  1  reset, asynchronous, active-low
cpu_addr  in  ADDR_W  CPU address
cpu_mem_oe  in  1  CPU store strobe, active-low (CPU drives D)
cpu_mem_we  in  1  CPU write-enable, active-low
cpu_dout  in  DATA_W  CPU store data
cpu_din  out  DATA_W  memory read data to CPU (= mem_din)
cpu_run  out  1  CPU clock enable; CPU advances only on edges where cpu_run=1
dma_req  in  1  DMA request, level; held with addr/we/wdata until ack seen
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_ack  out  1  high for exactly the cycle a DMA transfer occurs
dma_rdata  out  DATA_W  read data (= mem_din), valid when dma_ack=1
mem_addr  out  ADDR_W  memory address
mem_oe  out  1  active-low: arbiter drives mem_dout onto D
mem_we  out  1  active-low memory write strobe
mem_dout  out  DATA_W  write data to memory
mem_din  in  DATA_W  memory read data

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values:
  - state=CPU_OWN, cpu_run=1, burst_cnt=0, cool_cnt=0.
  - While rst=0: mem_oe=1, mem_we=1, dma_ack=0.
- States: CPU_OWN, DMA_OWN, COOL. The owner is registered; the bus mux is combinational from the owner.
- CPU_OWN:
  - mem_addr=cpu_addr, mem_oe=cpu_mem_oe, mem_we=cpu_mem_we, mem_dout=cpu_dout; dma_ack=0.
  - If dma_req=1 at posedge: go to DMA_OWN, cpu_run<=0, burst_cnt<=0.
- DMA_OWN, dma_req=1:
  - Transfer cycle: mem_addr=dma_addr, mem_dout=dma_wdata, dma_ack=1.
  - Write (dma_we=1): mem_oe=0 for the whole cycle; mem_we=~clk, i.e. strobe low only in the clk-high phase, matching the CPU store timing.
  - Read (dma_we=0): mem_oe=1, mem_we=1; requester samples dma_rdata at the closing posedge.
  - At posedge: if burst_cnt==MAX_BURST-1, go to COOL, cpu_run<=1, cool_cnt<=0. Otherwise burst_cnt<=burst_cnt+1.
- DMA_OWN, dma_req=0: no transfer, dma_ack=0, strobes inactive. At posedge go to CPU_OWN, cpu_run<=1.
- COOL:
  - Bus muxed to the CPU as in CPU_OWN; dma_ack=0 even if dma_req=1.
  - At posedge cool_cnt<=cool_cnt+1.
  - When cool_cnt==CPU_MIN-1: go to DMA_OWN (cpu_run<=0, burst_cnt<=0) if dma_req=1, else go to CPU_OWN.
- Latency: dma_req seen at posedge N gives the first ack in cycle N+1. The CPU loses its enable from the edge of that same cycle N+1.
- The CPU is never enabled on an edge where the bus is DMA-owned. cpu_run is registered and glitch-free.
- Counters: width clog2(MAX_BURST) and clog2(CPU_MIN), minimum 1. The compare is exact, so no wrap-around is reachable.
- Degenerate parameters:
  - MAX_BURST=1 alternates DMA and COOL every transfer.
  - A continuous dma_req yields the repeating pattern MAX_BURST DMA cycles, then CPU_MIN CPU cycles.
- Simultaneous events: dma_req rising during COOL is ignored until COOL ends. dma_req falling in the same cycle as an ack still completes that transfer.
- Reset mid-burst: immediate abandon with no further ack. Memory strobes go inactive asynchronously. A partial write strobe is cut at reset assertion.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state encoding (CPU_OWN=2'd0, DMA_OWN=2'd1, COOL=2'd2);
  - the inactive-strobe constant (2'b11 for {oe,we}).
- Package functions: the counter-width function.
- One natural sub-module, mem_bus_mux: purely combinational owner-select of addr/dout/oe/we. The arbiter FSM and counters stay in mem_bus_arbiter.

Test Plan:
- Reset with dma_req=1 held: mem_oe=mem_we=1, dma_ack=0, cpu_run=1 while rst=0. First ack appears 2 cycles after rst release.
- Single DMA write, addr 0x1234 data 0x5A, req for one ack: one ack cycle; mem_addr=0x1234, mem_dout=0x5A, mem_we low only in clk-high. cpu_run=0 for exactly one edge, then the CPU bus is restored.
- Single DMA read at 0x00FF with mem_din=0xC3: dma_ack=1 and dma_rdata=0xC3 in the same cycle; mem_oe=mem_we=1.
- Continuous dma_req with MAX_BURST=4, CPU_MIN=1: ack pattern 1111 0 1111 0…, with cpu_run the inverse.
- dma_req dropped after 2 acks: state returns to CPU_OWN next edge, cpu_run=1, burst_cnt restarts at 0 on the next request.
- rst asserted mid-burst during a write clk-high phase: mem_we goes to 1 asynchronously, no further ack, cpu_run=1 after release.
